// File: rtl/sw_button_ctrl.sv
// sw_button_ctrl: debounced two-button UI controller that sequences the stopwatch, captures laps and freezes split times.
//   Optional feature macro: SW_LAP_MEM_EN (lap ring memory, lap_count and lap read port).
//   Ports:
//     clk, reset            clock and synchronous active-high reset
//     btn_ss, btn_lr        raw asynchronous start/stop and lap/reset buttons
//     minutes, seconds      live stopwatch time
//     sw_start/stop/reset   one-cycle command pulses to the stopwatch
//     ui_state              IDLE=00 RUNNING=01 PAUSED=10 SPLIT=11
//     disp_min, disp_sec    registered display value (frozen while in SPLIT)
//     lap_count             number of valid laps, saturating at LAP_DEPTH
//     lap_rd_idx            lap read index, 0 = oldest valid lap
//     lap_rd_min/sec        combinational lap read data
module sw_button_ctrl #(
    parameter int DB_CYCLES = 4,
    parameter int LAP_DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         btn_ss,
    input  logic                         btn_lr,
    input  logic [7:0]                   minutes,
    input  logic [5:0]                   seconds,
    output logic                         sw_start,
    output logic                         sw_stop,
    output logic                         sw_reset,
    output logic [1:0]                   ui_state,
    output logic [7:0]                   disp_min,
    output logic [5:0]                   disp_sec,
    output logic [$clog2(LAP_DEPTH):0]   lap_count,
    input  logic [$clog2(LAP_DEPTH)-1:0] lap_rd_idx,
    output logic [7:0]                   lap_rd_min,
    output logic [5:0]                   lap_rd_sec
);
    localparam int CW = $clog2(DB_CYCLES + 1);
    localparam int AW = $clog2(LAP_DEPTH);

    typedef enum logic [1:0] {IDLE = 2'b00, RUNNING = 2'b01, PAUSED = 2'b10, SPLIT = 2'b11} state_t;

    // Bit 0 is the start/stop path, bit 1 the lap/reset path.
    logic [1:0] sync1_q, sync1_d, sync2_q, sync2_d, lvl_q, lvl_d, prev_q, prev_d, press;
    logic [CW-1:0] cnt_q [2];
    logic [CW-1:0] cnt_d [2];
    state_t state_q, state_d;
    logic start_q, start_d, stop_q, stop_d, clr_q, clr_d;
    logic [13:0] frozen_q, frozen_d, disp_q, disp_d;
    logic ss_ev, lr_ev, cap;

    always_comb begin
        sync1_d = {btn_lr, btn_ss};
        sync2_d = sync1_q;
        prev_d  = lvl_q;
        lvl_d   = lvl_q;
        for (int i = 0; i < 2; i++) begin
            // Counter tracks consecutive samples that disagree with the level; any agreeing sample restarts it.
            cnt_d[i] = '0;
            if (sync2_q[i] != lvl_q[i]) begin
                if (cnt_q[i] == CW'(DB_CYCLES - 1))
                    lvl_d[i] = sync2_q[i];
                else
                    cnt_d[i] = cnt_q[i] + CW'(1);
            end
        end
        press = lvl_q & ~prev_q;
    end

    // Start/stop has priority: a simultaneous lap/reset event is dropped.
    assign ss_ev = press[0];
    assign lr_ev = press[1] & ~press[0];

    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    state_d = ss_ev ? RUNNING : IDLE;
            RUNNING: state_d = ss_ev ? PAUSED : lr_ev ? SPLIT : RUNNING;
            SPLIT:   state_d = ss_ev ? PAUSED : lr_ev ? RUNNING : SPLIT;
            PAUSED:  state_d = ss_ev ? RUNNING : lr_ev ? IDLE : PAUSED;
        endcase
    end

    always_comb begin
        start_d  = ss_ev & (state_q == IDLE || state_q == PAUSED);
        stop_d   = ss_ev & (state_q == RUNNING || state_q == SPLIT);
        clr_d    = lr_ev & (state_q == PAUSED);
        cap      = lr_ev & (state_q == RUNNING);
        frozen_d = cap ? {minutes, seconds} : frozen_q;
        // On the entry edge the live value is exactly what gets frozen, so live is correct there too.
        disp_d   = (state_q == SPLIT && state_d == SPLIT) ? frozen_q : {minutes, seconds};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q  <= '0;
            sync2_q  <= '0;
            lvl_q    <= '0;
            prev_q   <= '0;
            cnt_q[0] <= '0;
            cnt_q[1] <= '0;
            start_q  <= 1'b0;
            stop_q   <= 1'b0;
            clr_q    <= 1'b0;
            frozen_q <= '0;
            disp_q   <= '0;
        end else begin
            sync1_q  <= sync1_d;
            sync2_q  <= sync2_d;
            lvl_q    <= lvl_d;
            prev_q   <= prev_d;
            cnt_q[0] <= cnt_d[0];
            cnt_q[1] <= cnt_d[1];
            start_q  <= start_d;
            stop_q   <= stop_d;
            clr_q    <= clr_d;
            frozen_q <= frozen_d;
            disp_q   <= disp_d;
        end
    end

    assign sw_start = start_q;
    assign sw_stop  = stop_q;
    assign sw_reset = clr_q;
    assign ui_state = state_q;
    assign disp_min = disp_q[13:6];
    assign disp_sec = disp_q[5:0];

`ifdef SW_LAP_MEM_EN
    logic [13:0] mem_q [LAP_DEPTH];
    logic [13:0] mem_d [LAP_DEPTH];
    logic [AW-1:0] wp_q, wp_d, rd_addr;
    logic [AW:0] lap_cnt_q, lap_cnt_d;
    logic [13:0] rd_word;

    always_comb begin
        mem_d     = mem_q;
        wp_d      = wp_q;
        lap_cnt_d = lap_cnt_q;
        if (clr_d) begin
            for (int i = 0; i < LAP_DEPTH; i++) mem_d[i] = '0;
            wp_d      = '0;
            lap_cnt_d = '0;
        end else if (cap) begin
            mem_d[wp_q] = {minutes, seconds};
            wp_d        = wp_q + AW'(1);
            lap_cnt_d   = (lap_cnt_q == (AW+1)'(LAP_DEPTH)) ? lap_cnt_q : lap_cnt_q + (AW+1)'(1);
        end
        // Until the ring wraps the oldest lap sits at 0; afterwards it is the next slot to be overwritten.
        rd_addr = ((lap_cnt_q == (AW+1)'(LAP_DEPTH)) ? wp_q : '0) + lap_rd_idx;
        rd_word = ({1'b0, lap_rd_idx} < lap_cnt_q) ? mem_q[rd_addr] : '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < LAP_DEPTH; i++) mem_q[i] <= '0;
            wp_q      <= '0;
            lap_cnt_q <= '0;
        end else begin
            mem_q     <= mem_d;
            wp_q      <= wp_d;
            lap_cnt_q <= lap_cnt_d;
        end
    end

    assign lap_count  = lap_cnt_q;
    assign lap_rd_min = rd_word[13:6];
    assign lap_rd_sec = rd_word[5:0];
`else
    logic unused_idx;
    assign unused_idx = ^lap_rd_idx;
    assign lap_count  = '0;
    assign lap_rd_min = '0;
    assign lap_rd_sec = '0;
`endif

endmodule

// File: tb/tb_sw_button_ctrl.sv
// tb_sw_button_ctrl: randomized self-checking bench for sw_button_ctrl against a spec-level reference model.
module tb_sw_button_ctrl;
    localparam int DB = 4;
    localparam int DEPTH = 4;
`ifdef SW_LAP_MEM_EN
    localparam bit LAP_EN = 1'b1;
`else
    localparam bit LAP_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset, btn_ss, btn_lr;
    logic [7:0] minutes;
    logic [5:0] seconds;
    logic sw_start, sw_stop, sw_reset;
    logic [1:0] ui_state;
    logic [7:0] disp_min, lap_rd_min;
    logic [5:0] disp_sec, lap_rd_sec;
    logic [2:0] lap_count;
    logic [1:0] lap_rd_idx;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    // Reference model state: 0 idle, 1 running, 2 paused, 3 split.
    int m_state;
    bit e_start, e_stop, e_clr;
    int e_disp, frozen;
    int laps[$];
    bit pend[2];
    bit lvl[2];
    logic [31:0] hist[2];

    sw_button_ctrl #(.DB_CYCLES(DB), .LAP_DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .btn_ss(btn_ss), .btn_lr(btn_lr),
        .minutes(minutes), .seconds(seconds),
        .sw_start(sw_start), .sw_stop(sw_stop), .sw_reset(sw_reset),
        .ui_state(ui_state), .disp_min(disp_min), .disp_sec(disp_sec),
        .lap_count(lap_count), .lap_rd_idx(lap_rd_idx),
        .lap_rd_min(lap_rd_min), .lap_rd_sec(lap_rd_sec)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s cycle %0d: got %0d expected %0d", tag, cyc, got, exp);
        end
    endtask

    // Advance the model by one rising edge using the inputs that were present at that edge.
    task automatic model_step();
        bit s, l, flip;
        bit raw[2];
        int live;
        if (reset) begin
            m_state = 0; e_start = 0; e_stop = 0; e_clr = 0;
            e_disp = 0; frozen = 0; laps.delete();
            pend[0] = 0; pend[1] = 0; lvl[0] = 0; lvl[1] = 0;
            hist[0] = '0; hist[1] = '0;
            return;
        end
        live = int'(minutes) * 64 + int'(seconds);
        s = pend[0];
        l = pend[1] && !s;
        e_start = 0; e_stop = 0; e_clr = 0;
        case (m_state)
            0: if (s) begin e_start = 1; m_state = 1; end
            1: if (s) begin e_stop = 1; m_state = 2; end
               else if (l) begin
                   frozen = live;
                   laps.push_back(live);
                   if (laps.size() > DEPTH) void'(laps.pop_front());
                   m_state = 3;
               end
            2: if (s) begin e_start = 1; m_state = 1; end
               else if (l) begin e_clr = 1; laps.delete(); m_state = 0; end
            default: if (s) begin e_stop = 1; m_state = 2; end
               else if (l) m_state = 1;
        endcase
        e_disp = (m_state == 3) ? frozen : live;
        // Level flips once the last DB synchronized samples (raw delayed two edges) all disagree with it.
        raw[0] = btn_ss;
        raw[1] = btn_lr;
        for (int b = 0; b < 2; b++) begin
            hist[b] = {hist[b][30:0], raw[b]};
            flip = 1;
            for (int i = 2; i < DB + 2; i++)
                if (hist[b][i] == lvl[b]) flip = 0;
            pend[b] = flip && !lvl[b];
            if (flip) lvl[b] = !lvl[b];
        end
    endtask

    task automatic compare();
        int idx, exp_rd;
        idx = int'(lap_rd_idx);
        exp_rd = (LAP_EN && idx < laps.size()) ? laps[idx] : 0;
        chk("sw_start", int'(sw_start), int'(e_start));
        chk("sw_stop", int'(sw_stop), int'(e_stop));
        chk("sw_reset", int'(sw_reset), int'(e_clr));
        chk("ui_state", int'(ui_state), m_state);
        chk("disp", int'(disp_min) * 64 + int'(disp_sec), e_disp);
        chk("lap_count", int'(lap_count), LAP_EN ? laps.size() : 0);
        chk("lap_rd", int'(lap_rd_min) * 64 + int'(lap_rd_sec), exp_rd);
        chk("one_cmd", int'(int'(sw_start) + int'(sw_stop) + int'(sw_reset) <= 1), 1);
    endtask

    task automatic tick();
        @(posedge clk);
        cyc++;
        model_step();
        @(negedge clk);
        compare();
        if (seconds == 6'd59) begin
            seconds = 0;
            minutes = minutes + 8'd1;
        end else
            seconds = seconds + 6'd1;
        lap_rd_idx = 2'($urandom_range(0, DEPTH - 1));
    endtask

    task automatic press(input bit s, input bit l, input int hold, input int gap);
        btn_ss = s;
        btn_lr = l;
        repeat (hold) tick();
        btn_ss = 0;
        btn_lr = 0;
        repeat (gap) tick();
    endtask

    // Must start in IDLE with both debounced levels low.
    task automatic latency_test(input string tag);
        int n, extra;
        n = 0;
        extra = 0;
        btn_ss = 1;
        do begin
            tick();
            n++;
        end while (!sw_start && n < 20);
        chk(tag, n, DB + 3);
        repeat (15) begin
            tick();
            extra += int'(sw_start);
        end
        chk({tag, "_hold"}, extra, 0);
        btn_ss = 0;
        repeat (8) tick();
    endtask

    initial begin
        int seq[6];
        int cnt;
        seq = '{1, 0, 1, 1, 0, 1};
        reset = 1; btn_ss = 0; btn_lr = 0;
        minutes = 8'd2; seconds = 6'd10; lap_rd_idx = 0;
        repeat (2) tick();
        reset = 0;
        latency_test("lat_first");

        cnt = 0;
        foreach (seq[i]) begin
            btn_ss = seq[i][0];
            tick();
            cnt += int'(sw_stop);
        end
        repeat (12) begin
            tick();
            cnt += int'(sw_stop);
        end
        chk("bounce_stop", cnt, 1);
        chk("bounce_state", int'(ui_state), 2);
        btn_ss = 0;
        repeat (8) tick();

        press(1, 0, 8, 8);
        repeat (9) press(0, 1, 8, 8);
        chk("laps_full", int'(lap_count), LAP_EN ? DEPTH : 0);
        chk("laps_split", int'(ui_state), 3);
        press(1, 0, 8, 8);
        press(0, 1, 8, 8);
        chk("cleared_state", int'(ui_state), 0);
        chk("cleared_laps", int'(lap_count), 0);

        press(1, 0, 8, 8);
        press(1, 1, 8, 8);
        chk("simul_state", int'(ui_state), 2);
        chk("simul_laps", int'(lap_count), 0);

        press(1, 0, 8, 8);
        press(0, 1, 8, 8);
        btn_ss = 1;
        repeat (3) tick();
        reset = 1;
        btn_ss = 0;
        tick();
        chk("reset_state", int'(ui_state), 0);
        reset = 0;
        repeat (4) tick();
        latency_test("lat_after_reset");

        repeat (160) begin
            if ($urandom_range(0, 11) == 0) begin
                reset = 1;
                tick();
                reset = 0;
            end else
                press(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      $urandom_range(1, 9), $urandom_range(1, 9));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
